// File: rtl/sram_wb_pkg.sv
// sram_wb_pkg: shared types and constants for the SRAM strobe/nak responder
package sram_wb_pkg;
  localparam int DATA_W = 48;
  localparam int BE_W = 6;
  localparam int WB_BE_W = 4;
  localparam int CNT_W = 4;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;
  typedef struct packed {
    logic ce_n;
    logic oe_n;
    logic we_n;
    logic [BE_W-1:0] be_n;
    logic dq_oe;
  } sram_ctl_t;
  localparam sram_ctl_t SRAM_CTL_RST = '{ce_n: 1'b1, oe_n: 1'b1, we_n: 1'b1, be_n: {BE_W{1'b1}}, dq_oe: 1'b0};
endpackage

// File: rtl/sram_wb_responder_if.sv
// sram_wb_responder_if: single-outstanding strobe/nak request bus
interface sram_wb_responder_if;
  import sram_wb_pkg::*;
  logic stb;
  logic [31:0] addr;
  logic [WB_BE_W-1:0] we;
  logic [31:0] din;
  logic [DATA_W-1:0] dout;
  logic nak;
  modport master (output stb, addr, we, din, input dout, nak);
  modport slave (input stb, addr, we, din, output dout, nak);
endinterface

// File: rtl/sram_wb_readbuf.sv
// sram_wb_readbuf: one-entry read buffer (valid, address tag, data) with write invalidate
module sram_wb_readbuf
  import sram_wb_pkg::*;
#(
  parameter int ADDR_BITS = 20
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic                 inval,
  output logic                 hit,
  input  logic                 fill,
  input  logic [ADDR_BITS-1:0] fill_addr,
  input  logic [DATA_W-1:0]    fill_data,
  output logic [DATA_W-1:0]    data
);
  logic valid_q, valid_d;
  logic [ADDR_BITS-1:0] tag_q, tag_d;
  logic [DATA_W-1:0] data_q, data_d;
  assign hit = valid_q && tag_q == addr;
  assign data = data_q;
  always_comb begin
    valid_d = fill ? 1'b1 : (inval && hit) ? 1'b0 : valid_q;
    tag_d = fill ? fill_addr : tag_q;
    data_d = fill ? fill_data : data_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      valid_q <= 1'b0;
      tag_q <= '0;
      data_q <= '0;
    end else begin
      valid_q <= valid_d;
      tag_q <= tag_d;
      data_q <= data_d;
    end
endmodule

// File: rtl/sram_wb_responder.sv
// sram_wb_responder: strobe/nak bus to async 48-bit SRAM bridge; SRAM_WB_READBUF_EN adds a one-entry read buffer
module sram_wb_responder
  import sram_wb_pkg::*;
#(
  parameter int ADDR_BITS = 20,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sram_wb_responder_if.slave   wb,
  output logic [ADDR_BITS-1:0] sram_addr,
  input  logic [DATA_W-1:0]    sram_dq_i,
  output logic [DATA_W-1:0]    sram_dq_o,
  output logic                 sram_dq_oe,
  output logic                 sram_ce_n,
  output logic                 sram_oe_n,
  output logic                 sram_we_n,
  output logic [BE_W-1:0]      sram_be_n
);
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [WB_BE_W-1:0] we_q, we_d;
  logic [31:0] din_q, din_d;
  logic hit_q, hit_d;
  logic nak_q, nak_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  sram_ctl_t ctl_q, ctl_d;
  logic wr, rd_hit, buf_hit, fill;
  logic [DATA_W-1:0] buf_data;
  logic unused_addr;
  assign wr = |we_q;
  assign rd_hit = ~|wb.we && buf_hit;
  assign fill = state_q == DONE && !wr && !hit_q;
  assign unused_addr = ^wb.addr[31:ADDR_BITS];
`ifdef SRAM_WB_READBUF_EN
  sram_wb_readbuf #(.ADDR_BITS(ADDR_BITS)) u_readbuf (
    .clk(clk),
    .rst_n(rst_n),
    .addr(wb.addr[ADDR_BITS-1:0]),
    .inval(state_q == IDLE && wb.stb && |wb.we),
    .hit(buf_hit),
    .fill(fill),
    .fill_addr(addr_q),
    .fill_data(sram_dq_i),
    .data(buf_data)
  );
`else
  assign buf_hit = 1'b0;
  assign buf_data = '0;
`endif
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    addr_d = addr_q;
    we_d = we_q;
    din_d = din_q;
    hit_d = hit_q;
    nak_d = 1'b1;
    dout_d = dout_q;
    ctl_d = SRAM_CTL_RST;
    case (state_q)
      IDLE: if (wb.stb) begin
        addr_d = wb.addr[ADDR_BITS-1:0];
        we_d = wb.we;
        din_d = wb.din;
        hit_d = rd_hit;
        state_d = rd_hit ? DONE : SETUP;
      end
      SETUP: begin
        cnt_d = CNT_W'(WAIT_CYCLES - 1);
        state_d = ACCESS;
        ctl_d.ce_n = 1'b0;
        ctl_d.be_n = wr ? {2'b11, ~we_q} : '0;
        ctl_d.dq_oe = wr;
      end
      ACCESS: begin
        cnt_d = cnt_q - 1'b1;
        state_d = cnt_q == '0 ? DONE : ACCESS;
        ctl_d.ce_n = 1'b0;
        ctl_d.be_n = ctl_q.be_n;
        ctl_d.oe_n = wr;
        ctl_d.we_n = !wr;
        ctl_d.dq_oe = wr;
      end
      DONE: begin
        state_d = IDLE;
        nak_d = 1'b0;
        ctl_d.ce_n = ctl_q.ce_n;
        ctl_d.be_n = ctl_q.be_n;
        ctl_d.dq_oe = ctl_q.dq_oe;
        dout_d = hit_q ? buf_data : wr ? dout_q : sram_dq_i;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      addr_q <= '0;
      we_q <= '0;
      din_q <= '0;
      hit_q <= 1'b0;
      nak_q <= 1'b1;
      dout_q <= '0;
      ctl_q <= SRAM_CTL_RST;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      addr_q <= addr_d;
      we_q <= we_d;
      din_q <= din_d;
      hit_q <= hit_d;
      nak_q <= nak_d;
      dout_q <= dout_d;
      ctl_q <= ctl_d;
    end
  assign wb.nak = nak_q;
  assign wb.dout = dout_q;
  assign sram_addr = addr_q;
  assign sram_dq_o = {{(DATA_W-32){1'b0}}, din_q};
  assign sram_dq_oe = ctl_q.dq_oe;
  assign sram_ce_n = ctl_q.ce_n;
  assign sram_oe_n = ctl_q.oe_n;
  assign sram_we_n = ctl_q.we_n;
  assign sram_be_n = ctl_q.be_n;
endmodule

// File: tb/tb_sram_wb_responder.sv
// tb_sram_wb_responder: directed self-checking bench with a byte-lane SRAM model
module tb_sram_wb_responder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  sram_wb_responder_if bus();
  logic [19:0] sram_addr;
  logic [47:0] sram_dq_i, sram_dq_o;
  logic sram_dq_oe, ce_n, oe_n, we_n;
  logic [5:0] be_n;
  int total = 0;
  int bad = 0;
  logic [47:0] mem [int unsigned];

  always #5 clk = ~clk;

  sram_wb_responder dut (
    .clk(clk),
    .rst_n(rst_n),
    .wb(bus),
    .sram_addr(sram_addr),
    .sram_dq_i(sram_dq_i),
    .sram_dq_o(sram_dq_o),
    .sram_dq_oe(sram_dq_oe),
    .sram_ce_n(ce_n),
    .sram_oe_n(oe_n),
    .sram_we_n(we_n),
    .sram_be_n(be_n)
  );

  function automatic logic [47:0] mem_rd(input logic [19:0] a);
    return mem.exists(int'(a)) ? mem[int'(a)] : {4'hC, a, 4'h3, ~a};
  endfunction

  assign sram_dq_i = (!ce_n && !oe_n) ? mem_rd(sram_addr) : 48'h0;

  always @(posedge clk)
    if (!ce_n && !we_n && sram_dq_oe) begin : wr_model
      logic [47:0] v;
      v = mem_rd(sram_addr);
      for (int b = 0; b < 6; b++)
        if (!be_n[b]) v[8*b +: 8] = sram_dq_o[8*b +: 8];
      mem[int'(sram_addr)] = v;
    end

  task automatic do_req(input logic [31:0] a, input logic [3:0] we, input logic [31:0] d,
                        output int nak_k, output int nak_n, output int n_oe, output int n_we,
                        output int n_ce, output int n_dqoe, output logic [5:0] be_seen,
                        output logic [47:0] dq_seen, output logic [47:0] dout_seen);
    bus.stb = 1'b1;
    bus.addr = a;
    bus.we = we;
    bus.din = d;
    @(posedge clk);
    #1 bus.stb = 1'b0;
    nak_k = -1;
    nak_n = 0;
    n_oe = 0;
    n_we = 0;
    n_ce = 0;
    n_dqoe = 0;
    be_seen = '1;
    dq_seen = '0;
    dout_seen = '0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (!bus.nak) begin
        nak_n++;
        if (nak_k < 0) begin
          nak_k = k;
          dout_seen = bus.dout;
        end
      end
      if (!oe_n) n_oe++;
      if (!we_n) begin
        n_we++;
        dq_seen = sram_dq_o;
      end
      if (!ce_n) begin
        n_ce++;
        be_seen = be_n;
      end
      if (sram_dq_oe) n_dqoe++;
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    total++;
    if ({bus.nak, ce_n, oe_n, we_n, be_n, sram_dq_oe} !== {4'b1111, 6'h3F, 1'b0}) begin
      bad++;
      $display("FAIL reset_held_ctl: got %b expected %b", {bus.nak, ce_n, oe_n, we_n, be_n, sram_dq_oe}, {4'b1111, 6'h3F, 1'b0});
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if ({bus.nak, ce_n, oe_n, we_n} !== 4'b1111) begin
      bad++;
      $display("FAIL reset_strobes: got %b expected 1111", {bus.nak, ce_n, oe_n, we_n});
    end
    total++;
    if (be_n !== 6'h3F || sram_dq_oe !== 1'b0) begin
      bad++;
      $display("FAIL reset_be_oe: got be_n=%h dq_oe=%b expected be_n=3f dq_oe=0", be_n, sram_dq_oe);
    end
    total++;
    if (bus.dout !== 48'h0 || sram_addr !== 20'h0 || sram_dq_o !== 48'h0) begin
      bad++;
      $display("FAIL reset_data: got dout=%h addr=%h dq_o=%h expected zeros", bus.dout, sram_addr, sram_dq_o);
    end
  endtask

  task automatic test_read;
    int nk, nn, no, nw, nc, nd;
    logic [5:0] be;
    logic [47:0] dq, dout;
    do_req(32'h0000_0123, 4'h0, 32'h0, nk, nn, no, nw, nc, nd, be, dq, dout);
    total++;
    if (nk !== 4 || nn !== 1) begin
      bad++;
      $display("FAIL read_nak: got cycle=%0d count=%0d expected cycle=4 count=1", nk, nn);
    end
    total++;
    if (no !== 2 || nw !== 0 || nc !== 4 || nd !== 0) begin
      bad++;
      $display("FAIL read_strobes: got oe=%0d we=%0d ce=%0d dqoe=%0d expected 2 0 4 0", no, nw, nc, nd);
    end
    total++;
    if (be !== 6'h00) begin
      bad++;
      $display("FAIL read_be: got %b expected 000000", be);
    end
    total++;
    if (dout !== 48'hA5A5_0123_4567) begin
      bad++;
      $display("FAIL read_dout: got %h expected a5a501234567", dout);
    end
    total++;
    if (bus.dout !== 48'hA5A5_0123_4567) begin
      bad++;
      $display("FAIL read_dout_hold: got %h expected a5a501234567", bus.dout);
    end
  endtask

  task automatic test_write;
    int nk, nn, no, nw, nc, nd;
    logic [5:0] be;
    logic [47:0] dq, dout;
    do_req(32'h0000_0010, 4'b0101, 32'h1122_3344, nk, nn, no, nw, nc, nd, be, dq, dout);
    total++;
    if (nk !== 4 || nn !== 1) begin
      bad++;
      $display("FAIL write_nak: got cycle=%0d count=%0d expected cycle=4 count=1", nk, nn);
    end
    total++;
    if (nw !== 2 || no !== 0 || nd !== 4) begin
      bad++;
      $display("FAIL write_strobes: got we=%0d oe=%0d dqoe=%0d expected 2 0 4", nw, no, nd);
    end
    total++;
    if (be !== 6'b111010) begin
      bad++;
      $display("FAIL write_be: got %b expected 111010", be);
    end
    total++;
    if (dq !== 48'h0000_1122_3344) begin
      bad++;
      $display("FAIL write_dq: got %h expected 000011223344", dq);
    end
    total++;
    if (dout !== 48'hA5A5_0123_4567) begin
      bad++;
      $display("FAIL write_dout_kept: got %h expected a5a501234567", dout);
    end
    do_req(32'h0000_0010, 4'h0, 32'h0, nk, nn, no, nw, nc, nd, be, dq, dout);
    total++;
    if (nk !== 4 || dout !== 48'hC000_1022_FF44) begin
      bad++;
      $display("FAIL write_readback: got cycle=%0d dout=%h expected cycle=4 dout=c0001022ff44", nk, dout);
    end
  endtask

  task automatic test_stream;
    logic [31:0] a;
    logic [47:0] exp;
    int k, extra;
    bit got;
    a = 32'h000F_FEC0;
    bus.stb = 1'b1;
    bus.addr = a;
    bus.we = 4'h0;
    for (int i = 0; i < 640; i++) begin
      exp = mem_rd(a[19:0]);
      @(posedge clk);
      #1 bus.stb = 1'b0;
      k = -1;
      got = 1'b0;
      while (!got && k < 12) begin
        @(negedge clk);
        k++;
        if (!bus.nak) got = 1'b1;
      end
      total++;
      if (!got || k != 4) begin
        bad++;
        $display("FAIL stream_lat[%0d]: got nak=%b at cycle %0d expected nak=0 at cycle 4", i, got, k);
      end
      if (!got) break;
      total++;
      if (bus.dout !== exp) begin
        bad++;
        $display("FAIL stream_dout[%0d]: got %h expected %h", i, bus.dout, exp);
      end
      if (i < 639) begin
        a = a + 1;
        bus.addr = a;
        bus.stb = 1'b1;
      end
    end
    extra = 0;
    repeat (6) begin
      @(negedge clk);
      if (!bus.nak) extra++;
    end
    total++;
    if (extra !== 0) begin
      bad++;
      $display("FAIL stream_extra_nak: got %0d expected 0", extra);
    end
  endtask

  task automatic test_reset_mid;
    int nk, nn, no, nw, nc, nd, nak_low, ce_low;
    logic [5:0] be;
    logic [47:0] dq, dout;
    bus.stb = 1'b1;
    bus.addr = 32'h0000_0123;
    bus.we = 4'h0;
    @(posedge clk);
    #1 bus.stb = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (oe_n !== 1'b0) begin
      bad++;
      $display("FAIL midrst_in_access: got oe_n=%b expected 0", oe_n);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({bus.nak, ce_n, oe_n, we_n, be_n, sram_dq_oe} !== {4'b1111, 6'h3F, 1'b0}) begin
      bad++;
      $display("FAIL midrst_ctl: got %b expected %b", {bus.nak, ce_n, oe_n, we_n, be_n, sram_dq_oe}, {4'b1111, 6'h3F, 1'b0});
    end
    total++;
    if (bus.dout !== 48'h0 || sram_addr !== 20'h0) begin
      bad++;
      $display("FAIL midrst_data: got dout=%h addr=%h expected zeros", bus.dout, sram_addr);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    nak_low = 0;
    ce_low = 0;
    repeat (8) begin
      @(negedge clk);
      if (!bus.nak) nak_low++;
      if (!ce_n) ce_low++;
    end
    total++;
    if (nak_low !== 0 || ce_low !== 0) begin
      bad++;
      $display("FAIL midrst_no_nak: got nak_low=%0d ce_low=%0d expected 0 0", nak_low, ce_low);
    end
    do_req(32'h0000_0010, 4'h0, 32'h0, nk, nn, no, nw, nc, nd, be, dq, dout);
    total++;
    if (nk !== 4 || nn !== 1 || dout !== 48'hC000_1022_FF44) begin
      bad++;
      $display("FAIL midrst_recover: got cycle=%0d count=%0d dout=%h expected 4 1 c0001022ff44", nk, nn, dout);
    end
  endtask

  task automatic test_repeat_read;
    int nk, nn, no, nw, nc, nd;
    logic [5:0] be;
    logic [47:0] dq, dout;
    do_req(32'h0000_0040, 4'h0, 32'h0, nk, nn, no, nw, nc, nd, be, dq, dout);
    total++;
    if (nk !== 4 || no !== 2 || dout !== 48'hC000_403F_FFBF) begin
      bad++;
      $display("FAIL rpt_first: got cycle=%0d oe=%0d dout=%h expected 4 2 c000403fffbf", nk, no, dout);
    end
    do_req(32'h0000_0040, 4'h0, 32'h0, nk, nn, no, nw, nc, nd, be, dq, dout);
`ifdef SRAM_WB_READBUF_EN
    total++;
    if (nk !== 1 || nn !== 1 || nc !== 0 || no !== 0) begin
      bad++;
      $display("FAIL rpt_hit: got cycle=%0d count=%0d ce=%0d oe=%0d expected 1 1 0 0", nk, nn, nc, no);
    end
`else
    total++;
    if (nk !== 4 || nn !== 1 || no !== 2) begin
      bad++;
      $display("FAIL rpt_nobuf: got cycle=%0d count=%0d oe=%0d expected 4 1 2", nk, nn, no);
    end
`endif
    total++;
    if (dout !== 48'hC000_403F_FFBF) begin
      bad++;
      $display("FAIL rpt_second_dout: got %h expected c000403fffbf", dout);
    end
    do_req(32'h0000_0040, 4'b0001, 32'h0000_00AB, nk, nn, no, nw, nc, nd, be, dq, dout);
    do_req(32'h0000_0040, 4'h0, 32'h0, nk, nn, no, nw, nc, nd, be, dq, dout);
    total++;
    if (nk !== 4 || no !== 2 || dout !== 48'hC000_403F_FFAB) begin
      bad++;
      $display("FAIL rpt_after_write: got cycle=%0d oe=%0d dout=%h expected 4 2 c000403fffab", nk, no, dout);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.stb = 1'b0;
    bus.addr = '0;
    bus.we = '0;
    bus.din = '0;
    mem[32'h123] = 48'hA5A5_0123_4567;
    mem[32'h10] = 48'hC000_103F_FFEF;
    test_reset;
    test_read;
    test_write;
    test_stream;
    test_reset_mid;
    test_repeat_read;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
